// File: rtl/dual_issue_scheduler.sv
// Two-wide in-order issue scheduler: buffers fetched pairs and issues the two oldest
// instructions together when no intra-pair hazard exists, otherwise only the oldest.
module dual_issue_scheduler #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch_valid1,
   input  logic             fetch_valid2,
   input  logic [31:0]      fetch_instr1,
   input  logic [31:0]      fetch_instr2,
   input  logic [31:0]      fetch_pc1,
   input  logic [31:0]      fetch_pc2,
   output logic             fetch_ready,
   input  logic             issue_stall,
   input  logic             flush,
   output logic             issue_valid1,
   output logic             issue_valid2,
   output logic [31:0]      issue_instr1,
   output logic [31:0]      issue_instr2,
   output logic [31:0]      issue_pc1,
   output logic [31:0]      issue_pc2,
   output logic [CNT_W-1:0] perf_cycles,
   output logic [CNT_W-1:0] perf_issued,
   output logic [CNT_W-1:0] perf_dual
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   function automatic logic f_writes(input logic [6:0] op);
      return (op == OP_OP) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_LUI) ||
             (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR);
   endfunction

   function automatic logic f_uses_rs1(input logic [6:0] op);
      return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
   endfunction

   function automatic logic f_uses_rs2(input logic [6:0] op);
      return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

   function automatic logic f_mem(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   function automatic logic f_ctrl(input logic [6:0] op);
      return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
   endfunction

   logic [31:0]   r_instr [DEPTH];
   logic [31:0]   r_pc    [DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [CNT_W-1:0] r_cycles;
   logic [CNT_W-1:0] r_issued;
   logic [CNT_W-1:0] r_dual;

   logic [PW-1:0] w_b_idx;
   logic [31:0]   w_instr_a;
   logic [31:0]   w_instr_b;
   logic [6:0]    w_op_a;
   logic [6:0]    w_op_b;
   logic [4:0]    w_rd_a;
   logic          w_raw;
   logic          w_waw;
   logic          w_mem_conflict;
   logic          w_ctrl;
   logic          w_pair_ok;
   logic          w_push;
   logic          w_push2;
   logic [CW-1:0] w_push_n;
   logic [CW-1:0] w_pop_n;

   assign w_b_idx   = r_rd_ptr + PW'(1);
   assign w_instr_a = r_instr[r_rd_ptr];
   assign w_instr_b = r_instr[w_b_idx];
   assign w_op_a    = w_instr_a[6:0];
   assign w_op_b    = w_instr_b[6:0];
   assign w_rd_a    = w_instr_a[11:7];

   // Writes to x0 are discarded, so they never create a dependency.
   assign w_raw = f_writes(w_op_a) && (w_rd_a != 5'd0) &&
                  ((f_uses_rs1(w_op_b) && (w_instr_b[19:15] == w_rd_a)) ||
                   (f_uses_rs2(w_op_b) && (w_instr_b[24:20] == w_rd_a)));
   assign w_waw = f_writes(w_op_a) && f_writes(w_op_b) && (w_rd_a != 5'd0) &&
                  (w_rd_a == w_instr_b[11:7]);
   assign w_mem_conflict = f_mem(w_op_a) && f_mem(w_op_b);
   assign w_ctrl         = f_ctrl(w_op_a) || f_ctrl(w_op_b);
   assign w_pair_ok      = !(w_raw || w_waw || w_mem_conflict || w_ctrl);

   assign fetch_ready  = (r_count <= CW'(DEPTH - 2));
   assign issue_valid1 = (r_count >= CW'(1)) && !flush;
   assign issue_valid2 = (r_count >= CW'(2)) && !flush && w_pair_ok;
   assign issue_instr1 = issue_valid1 ? w_instr_a : 32'd0;
   assign issue_pc1    = issue_valid1 ? r_pc[r_rd_ptr] : 32'd0;
   assign issue_instr2 = issue_valid2 ? w_instr_b : 32'd0;
   assign issue_pc2    = issue_valid2 ? r_pc[w_b_idx] : 32'd0;

   assign w_push   = fetch_ready && fetch_valid1 && !flush;
   assign w_push2  = w_push && fetch_valid2;
   assign w_push_n = CW'(w_push) + CW'(w_push2);
   assign w_pop_n  = (!issue_stall && !flush) ? (CW'(issue_valid1) + CW'(issue_valid2)) : CW'(0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= r_rd_ptr + PW'(w_pop_n);
         r_wr_ptr <= r_wr_ptr + PW'(w_push_n);
         r_count  <= r_count + w_push_n - w_pop_n;
      end
   end

   // Storage needs no reset: the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr[r_wr_ptr] <= fetch_instr1;
         r_pc[r_wr_ptr]    <= fetch_pc1;
      end
      if (w_push2) begin
         r_instr[r_wr_ptr + PW'(1)] <= fetch_instr2;
         r_pc[r_wr_ptr + PW'(1)]    <= fetch_pc2;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cycles <= '0;
         r_issued <= '0;
         r_dual   <= '0;
      end else begin
         r_cycles <= r_cycles + CNT_W'(1);
         if (!issue_stall) begin
            r_issued <= r_issued + CNT_W'(issue_valid1) + CNT_W'(issue_valid2);
            r_dual   <= r_dual + CNT_W'(issue_valid2);
         end
      end
   end

   assign perf_cycles = r_cycles;
   assign perf_issued = r_issued;
   assign perf_dual   = r_dual;
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: pairing rules, stall, flush, reset and
// back-to-back streaming with hand-encoded RV32 instructions.
module tb_dual_issue_scheduler;
   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_valid1, fetch_valid2;
   logic [31:0] fetch_instr1, fetch_instr2, fetch_pc1, fetch_pc2;
   logic        fetch_ready;
   logic        issue_stall, flush;
   logic        issue_valid1, issue_valid2;
   logic [31:0] issue_instr1, issue_instr2, issue_pc1, issue_pc2;
   logic [31:0] perf_cycles, perf_issued, perf_dual;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [31:0] ADDI5    = 32'h00100293; // addi x5,x0,1
   localparam logic [31:0] ADDI6    = 32'h00200313; // addi x6,x0,2
   localparam logic [31:0] ADDI5B   = 32'h00200293; // addi x5,x0,2
   localparam logic [31:0] ADD6_5_1 = 32'h00128333; // add x6,x5,x1
   localparam logic [31:0] ADDI0    = 32'h00100013; // addi x0,x0,1
   localparam logic [31:0] ADD6_0_1 = 32'h00100333; // add x6,x0,x1
   localparam logic [31:0] LW7      = 32'h0000A383; // lw x7,0(x1)
   localparam logic [31:0] SW8      = 32'h00812223; // sw x8,4(x2)
   localparam logic [31:0] BEQ      = 32'h00208463; // beq x1,x2,8
   localparam logic [31:0] ADDI3    = 32'h00100193; // addi x3,x0,1

   dual_issue_scheduler #(.DEPTH(4), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .fetch_valid1(fetch_valid1), .fetch_valid2(fetch_valid2),
      .fetch_instr1(fetch_instr1), .fetch_instr2(fetch_instr2),
      .fetch_pc1(fetch_pc1), .fetch_pc2(fetch_pc2),
      .fetch_ready(fetch_ready), .issue_stall(issue_stall), .flush(flush),
      .issue_valid1(issue_valid1), .issue_valid2(issue_valid2),
      .issue_instr1(issue_instr1), .issue_instr2(issue_instr2),
      .issue_pc1(issue_pc1), .issue_pc2(issue_pc2),
      .perf_cycles(perf_cycles), .perf_issued(perf_issued), .perf_dual(perf_dual)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [11:0] imm);
      return {imm, 5'd0, 3'd0, rd, 7'h13};
   endfunction

   task automatic clk_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pair(input logic v2, input logic [31:0] i1, input logic [31:0] i2,
                             input logic [31:0] p1);
      fetch_valid1 = 1'b1;
      fetch_valid2 = v2;
      fetch_instr1 = i1;
      fetch_instr2 = i2;
      fetch_pc1    = p1;
      fetch_pc2    = p1 + 32'd4;
   endtask

   task automatic drive_idle();
      fetch_valid1 = 1'b0;
      fetch_valid2 = 1'b0;
      fetch_instr1 = '0;
      fetch_instr2 = '0;
      fetch_pc1    = '0;
      fetch_pc2    = '0;
   endtask

   task automatic do_reset();
      drive_idle();
      issue_stall = 1'b0;
      flush       = 1'b0;
      reset       = 1'b0;
      clk_edge();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_cmp++; if (issue_valid1 !== 1'b0) begin n_err++; $display("FAIL rst_v1: got %b want 0", issue_valid1); end
      n_cmp++; if (issue_valid2 !== 1'b0) begin n_err++; $display("FAIL rst_v2: got %b want 0", issue_valid2); end
      n_cmp++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", fetch_ready); end
      n_cmp++; if ({issue_instr1, issue_pc1, issue_instr2, issue_pc2} !== 128'd0) begin n_err++; $display("FAIL rst_outs: got %h %h want 0", issue_instr1, issue_pc1); end
      n_cmp++; if ({perf_cycles, perf_issued, perf_dual} !== 96'd0) begin n_err++; $display("FAIL rst_perf: got %0d %0d %0d want 0", perf_cycles, perf_issued, perf_dual); end
      clk_edge();
      @(negedge clk);
      n_cmp++; if (perf_cycles !== 32'd1) begin n_err++; $display("FAIL rst_cycles1: got %0d want 1", perf_cycles); end
   endtask

   task automatic test_dual_pair();
      do_reset();
      drive_pair(1'b1, ADDI5, ADDI6, 32'h100);
      @(negedge clk);
      n_cmp++; if (issue_valid1 !== 1'b0) begin n_err++; $display("FAIL pair_latency: got %b want 0", issue_valid1); end
      clk_edge();
      drive_idle();
      @(negedge clk);
      n_cmp++; if ({issue_valid1, issue_valid2} !== 2'b11) begin n_err++; $display("FAIL pair_valids: got %b want 11", {issue_valid1, issue_valid2}); end
      n_cmp++; if (issue_instr1 !== ADDI5 || issue_instr2 !== ADDI6) begin n_err++; $display("FAIL pair_instr: got %h %h want %h %h", issue_instr1, issue_instr2, ADDI5, ADDI6); end
      n_cmp++; if (issue_pc1 !== 32'h100 || issue_pc2 !== 32'h104) begin n_err++; $display("FAIL pair_pc: got %h %h want 100 104", issue_pc1, issue_pc2); end
      clk_edge();
      @(negedge clk);
      n_cmp++; if (issue_valid1 !== 1'b0) begin n_err++; $display("FAIL pair_empty: got %b want 0", issue_valid1); end
      n_cmp++; if (perf_issued !== 32'd2 || perf_dual !== 32'd1 || perf_cycles !== 32'd2) begin n_err++; $display("FAIL pair_perf: got %0d %0d %0d want 2 1 2", perf_issued, perf_dual, perf_cycles); end
   endtask

   task automatic test_raw_waw();
      do_reset();
      drive_pair(1'b1, ADDI5, ADD6_5_1, 32'h200);
      clk_edge();
      drive_idle();
      @(negedge clk);
      n_cmp++; if ({issue_valid1, issue_valid2} !== 2'b10 || issue_instr1 !== ADDI5) begin n_err++; $display("FAIL raw_c1: got %b %h want 10 %h", {issue_valid1, issue_valid2}, issue_instr1, ADDI5); end
      n_cmp++; if (issue_instr2 !== 32'd0 || issue_pc2 !== 32'd0) begin n_err++; $display("FAIL raw_slot2_zero: got %h %h want 0 0", issue_instr2, issue_pc2); end
      clk_edge();
      @(negedge clk);
      n_cmp++; if ({issue_valid1, issue_valid2} !== 2'b10 || issue_instr1 !== ADD6_5_1 || issue_pc1 !== 32'h204) begin n_err++; $display("FAIL raw_c2: got %b %h %h want 10 %h 204", {issue_valid1, issue_valid2}, issue_instr1, issue_pc1, ADD6_5_1); end
      clk_edge();
      @(negedge clk);
      n_cmp++; if (perf_issued !== 32'd2 || perf_dual !== 32'd0) begin n_err++; $display("FAIL raw_perf: got %0d %0d want 2 0", perf_issued, perf_dual); end
      drive_pair(1'b1, ADDI0, ADD6_0_1, 32'h300);
      clk_edge();
      drive_idle();
      @(negedge clk);
      n_cmp++; if ({issue_valid1, issue_valid2} !== 2'b11 || issue_instr2 !== ADD6_0_1) begin n_err++; $display("FAIL raw_x0_dual: got %b %h want 11 %h", {issue_valid1, issue_valid2}, issue_instr2, ADD6_0_1); end
      clk_edge();
      drive_pair(1'b1, ADDI5, ADDI5B, 32'h400);
      clk_edge();
      drive_idle();
      @(negedge clk);
      n_cmp++; if ({issue_valid1, issue_valid2} !== 2'b10) begin n_err++; $display("FAIL waw_single: got %b want 10", {issue_valid1, issue_valid2}); end
      clk_edge();
      clk_edge();
      @(negedge clk);
      n_cmp++; if (perf_issued !== 32'd6 || perf_dual !== 32'd1) begin n_err++; $display("FAIL waw_perf: got %0d %0d want 6 1", perf_issued, perf_dual); end
   endtask

   task automatic test_mem_ctrl();
      do_reset();
      drive_pair(1'b1, LW7, SW8, 32'h500);
      clk_edge();
      drive_idle();
      @(negedge clk);
      n_cmp++; if ({issue_valid1, issue_valid2} !== 2'b10 || issue_instr1 !== LW7) begin n_err++; $display("FAIL mem_c1: got %b %h want 10 %h", {issue_valid1, issue_valid2}, issue_instr1, LW7); end
      clk_edge();
      @(negedge clk);
      n_cmp++; if ({issue_valid1, issue_valid2} !== 2'b10 || issue_instr1 !== SW8) begin n_err++; $display("FAIL mem_c2: got %b %h want 10 %h", {issue_valid1, issue_valid2}, issue_instr1, SW8); end
      drive_pair(1'b1, BEQ, ADDI3, 32'h600);
      clk_edge();
      drive_idle();
      @(negedge clk);
      n_cmp++; if ({issue_valid1, issue_valid2} !== 2'b10 || issue_instr1 !== BEQ) begin n_err++; $display("FAIL ctrl_a_alone: got %b %h want 10 %h", {issue_valid1, issue_valid2}, issue_instr1, BEQ); end
      clk_edge();
      @(negedge clk);
      n_cmp++; if ({issue_valid1, issue_valid2} !== 2'b10 || issue_instr1 !== ADDI3) begin n_err++; $display("FAIL ctrl_next: got %b %h want 10 %h", {issue_valid1, issue_valid2}, issue_instr1, ADDI3); end
      drive_pair(1'b1, ADDI5, BEQ, 32'h700);
      clk_edge();
      drive_idle();
      @(negedge clk);
      n_cmp++; if ({issue_valid1, issue_valid2} !== 2'b10 || issue_instr1 !== ADDI5) begin n_err++; $display("FAIL ctrl_b_blocks: got %b %h want 10 %h", {issue_valid1, issue_valid2}, issue_instr1, ADDI5); end
      clk_edge();
      clk_edge();
      @(negedge clk);
      n_cmp++; if (issue_valid1 !== 1'b0 || perf_issued !== 32'd6 || perf_dual !== 32'd0) begin n_err++; $display("FAIL memctrl_perf: got %b %0d %0d want 0 6 0", issue_valid1, perf_issued, perf_dual); end
   endtask

   task automatic test_full_stall();
      do_reset();
      issue_stall = 1'b1;
      drive_pair(1'b1, ADDI5, ADDI6, 32'h800);
      clk_edge();
      drive_pair(1'b1, LW7, SW8, 32'h808);
      @(negedge clk);
      n_cmp++; if (fetch_ready !== 1'b1 || {issue_valid1, issue_valid2} !== 2'b11) begin n_err++; $display("FAIL stall_half: got %b %b want 1 11", fetch_ready, {issue_valid1, issue_valid2}); end
      clk_edge();
      drive_pair(1'b1, BEQ, ADDI3, 32'h810);
      @(negedge clk);
      n_cmp++; if (fetch_ready !== 1'b0) begin n_err++; $display("FAIL stall_full_ready: got %b want 0", fetch_ready); end
      n_cmp++; if (issue_instr1 !== ADDI5 || issue_instr2 !== ADDI6 || issue_pc1 !== 32'h800) begin n_err++; $display("FAIL stall_hold: got %h %h %h want %h %h 800", issue_instr1, issue_instr2, issue_pc1, ADDI5, ADDI6); end
      clk_edge();
      drive_idle();
      issue_stall = 1'b0;
      @(negedge clk);
      n_cmp++; if (perf_issued !== 32'd0 || {issue_valid1, issue_valid2} !== 2'b11 || issue_instr1 !== ADDI5) begin n_err++; $display("FAIL stall_no_pop: got %0d %b %h want 0 11 %h", perf_issued, {issue_valid1, issue_valid2}, issue_instr1, ADDI5); end
      clk_edge();
      @(negedge clk);
      n_cmp++; if (fetch_ready !== 1'b1 || issue_instr1 !== LW7 || issue_valid2 !== 1'b0) begin n_err++; $display("FAIL stall_release: got %b %h %b want 1 %h 0", fetch_ready, issue_instr1, issue_valid2, LW7); end
      clk_edge();
      @(negedge clk);
      n_cmp++; if (issue_instr1 !== SW8 || issue_pc1 !== 32'h80c) begin n_err++; $display("FAIL stall_sw: got %h %h want %h 80c", issue_instr1, issue_pc1, SW8); end
      clk_edge();
      @(negedge clk);
      n_cmp++; if (issue_valid1 !== 1'b0 || perf_issued !== 32'd4 || perf_dual !== 32'd1) begin n_err++; $display("FAIL stall_drop_full_push: got %b %0d %0d want 0 4 1", issue_valid1, perf_issued, perf_dual); end
   endtask

   task automatic test_flush();
      do_reset();
      issue_stall = 1'b1;
      drive_pair(1'b1, ADDI5, ADDI6, 32'h900);
      clk_edge();
      drive_pair(1'b0, LW7, 32'd0, 32'h908);
      clk_edge();
      drive_pair(1'b1, BEQ, ADDI3, 32'h90c);
      @(negedge clk);
      n_cmp++; if ({issue_valid1, issue_valid2} !== 2'b11 || fetch_ready !== 1'b0) begin n_err++; $display("FAIL flush_pre: got %b %b want 11 0", {issue_valid1, issue_valid2}, fetch_ready); end
      #1;
      issue_stall = 1'b0;
      flush       = 1'b1;
      drive_pair(1'b0, BEQ, 32'd0, 32'h90c);
      #1;
      n_cmp++; if ({issue_valid1, issue_valid2} !== 2'b00 || issue_instr1 !== 32'd0) begin n_err++; $display("FAIL flush_comb: got %b %h want 00 0", {issue_valid1, issue_valid2}, issue_instr1); end
      clk_edge();
      flush = 1'b0;
      drive_idle();
      @(negedge clk);
      n_cmp++; if (issue_valid1 !== 1'b0 || fetch_ready !== 1'b1) begin n_err++; $display("FAIL flush_empty: got %b %b want 0 1", issue_valid1, fetch_ready); end
      clk_edge();
      @(negedge clk);
      n_cmp++; if (issue_valid1 !== 1'b0 || perf_issued !== 32'd0) begin n_err++; $display("FAIL flush_discard: got %b %0d want 0 0", issue_valid1, perf_issued); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      issue_stall = 1'b1;
      drive_pair(1'b1, ADDI5, ADDI6, 32'ha00);
      clk_edge();
      drive_idle();
      issue_stall = 1'b0;
      @(negedge clk);
      n_cmp++; if (issue_valid1 !== 1'b1) begin n_err++; $display("FAIL rmid_pre: got %b want 1", issue_valid1); end
      clk_edge();
      drive_pair(1'b1, LW7, SW8, 32'ha08);
      clk_edge();
      drive_idle();
      reset = 1'b0;
      clk_edge();
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (issue_valid1 !== 1'b0 || fetch_ready !== 1'b1) begin n_err++; $display("FAIL rmid_state: got %b %b want 0 1", issue_valid1, fetch_ready); end
      n_cmp++; if ({perf_cycles, perf_issued, perf_dual} !== 96'd0) begin n_err++; $display("FAIL rmid_perf: got %0d %0d %0d want 0 0 0", perf_cycles, perf_issued, perf_dual); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive_pair(1'b1, enc_addi(5'd1, 12'd1), enc_addi(5'd2, 12'd2), 32'h1000);
      clk_edge();
      drive_pair(1'b1, enc_addi(5'd3, 12'd3), enc_addi(5'd4, 12'd4), 32'h1008);
      @(negedge clk);
      n_cmp++; if ({issue_valid1, issue_valid2} !== 2'b11 || issue_instr1 !== enc_addi(5'd1, 12'd1) || fetch_ready !== 1'b1) begin n_err++; $display("FAIL b2b_1: got %b %h %b", {issue_valid1, issue_valid2}, issue_instr1, fetch_ready); end
      clk_edge();
      drive_pair(1'b1, enc_addi(5'd5, 12'd5), enc_addi(5'd6, 12'd6), 32'h1010);
      @(negedge clk);
      n_cmp++; if ({issue_valid1, issue_valid2} !== 2'b11 || issue_instr1 !== enc_addi(5'd3, 12'd3) || issue_pc2 !== 32'h100c) begin n_err++; $display("FAIL b2b_2: got %b %h %h", {issue_valid1, issue_valid2}, issue_instr1, issue_pc2); end
      clk_edge();
      drive_idle();
      @(negedge clk);
      n_cmp++; if ({issue_valid1, issue_valid2} !== 2'b11 || issue_instr2 !== enc_addi(5'd6, 12'd6) || issue_pc1 !== 32'h1010) begin n_err++; $display("FAIL b2b_wrap: got %b %h %h", {issue_valid1, issue_valid2}, issue_instr2, issue_pc1); end
      clk_edge();
      @(negedge clk);
      n_cmp++; if (issue_valid1 !== 1'b0 || perf_issued !== 32'd6 || perf_dual !== 32'd3 || perf_cycles !== 32'd4) begin n_err++; $display("FAIL b2b_perf: got %b %0d %0d %0d want 0 6 3 4", issue_valid1, perf_issued, perf_dual, perf_cycles); end
   endtask

   initial begin
      reset = 1'b0;
      issue_stall = 1'b0;
      flush = 1'b0;
      drive_idle();
      test_reset();
      test_dual_pair();
      test_raw_waw();
      test_mem_ctrl();
      test_full_stall();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- In-order issue scheduler between fetch and decode of the two-wide pipeline.
- Buffers fetched instruction pairs in a small FIFO.
- Each cycle it decides whether the two oldest instructions can issue together into slots 1/2 or only the oldest issues into slot 1, applying the intra-pair RAW, WAW, memory-port and control-flow rules.
- Flushes on mispredict and keeps issue performance counters.

Parameters:
DEPTH, 4, instruction buffer entries; power of 2, >= 2
CNT_W, 32, performance counter width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
fetch_valid1  input  1  fetch slot 1 instruction valid
fetch_valid2  input  1  fetch slot 2 instruction valid (ignored unless fetch_valid1)
fetch_instr1  input  32  slot 1 instruction
fetch_instr2  input  32  slot 2 instruction
fetch_pc1  input  32  slot 1 PC
fetch_pc2  input  32  slot 2 PC
fetch_ready  output  1  buffer can accept two instructions this cycle
issue_stall  input  1  backend stall; hold issue outputs, no pop
flush  input  1  mispredict flush
issue_valid1  output  1  slot 1 issuing
issue_valid2  output  1  slot 2 co-issuing
issue_instr1  output  32  slot 1 instruction
issue_instr2  output  32  slot 2 instruction
issue_pc1  output  32  slot 1 PC
issue_pc2  output  32  slot 2 PC
perf_cycles  output  CNT_W  cycles since reset
perf_issued  output  CNT_W  instructions issued
perf_dual  output  CNT_W  cycles with two instructions issued

Behaviour:
- Reset (reset==0 at posedge): buffer empty, pointers and count 0, all perf counters 0. Consequently issue_valid1/2=0, fetch_ready=1, and issue_instr/pc outputs are 0.
- fetch_ready = (DEPTH - count) >= 2, computed from the registered count; a same-edge pop is not credited.
- Push at posedge when fetch_ready && fetch_valid1 && !flush:
  - push instr1/pc1;
  - also push instr2/pc2 behind it if fetch_valid2.
- Latency: an instruction pushed at edge N is visible on the issue outputs from cycle N+1 at the earliest.
- Head A = oldest entry, B = next entry. Outputs are combinational from A/B.
  - issue_valid1 = (count>=1) && !flush.
  - issue_valid2 = (count>=2) && !flush && pair_ok.
  - Slot 2 outputs are 0 when !issue_valid2.
- Decode fields: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
  - writes: opcode in {0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111}.
  - uses_rs1: all opcodes except 0110111, 0010111, 1101111.
  - uses_rs2: opcode in {0110011, 0100011, 1100011}.
  - mem: opcode in {0000011, 0100011}.
  - ctrl: opcode in {1100011, 1101111, 1100111}.
- pair_ok = 0 when any of the following holds, else 1:
  - RAW: A.writes && A.rd!=0 && ((B.uses_rs1 && B.rs1==A.rd) || (B.uses_rs2 && B.rs2==A.rd)).
  - WAW: A.writes && B.writes && A.rd!=0 && A.rd==B.rd.
  - Memory port: A.mem && B.mem.
  - Control flow: A.ctrl || B.ctrl. A control instruction always issues alone in slot 1.
- Pop at posedge when !issue_stall && !flush: remove issue_valid1+issue_valid2 entries. Push and pop on the same edge are both applied. Pointers wrap modulo DEPTH.
- issue_stall=1: outputs hold their values (buffer head unchanged); pushes are still accepted.
- Flush: buffer emptied at the edge, and the same-cycle fetch push is discarded. Flush has priority over stall, push and pop. Issue valids are forced to 0 combinationally during the flush cycle.
- Perf counters:
  - perf_cycles increments every cycle out of reset.
  - perf_issued += issue_valid1+issue_valid2 when !issue_stall.
  - perf_dual += 1 when issue_valid2 && !issue_stall.
  - All counters wrap at 2^CNT_W.
- Issue order is strictly program order. Slot 2 never issues an instruction younger than one left in the buffer.

Test Plan:
- Push pair addi x5,x0,1 / addi x6,x0,2 into empty buffer -> next cycle issue_valid1=issue_valid2=1; after that edge count=0, perf_issued=2, perf_dual=1.
- Push addi x5,x0,1 / add x6,x5,x1 (RAW) -> cycle 1 slot 1 only; cycle 2 add issues in slot 1; perf_dual=0. Repeat with rd=x0 in A -> dual issue.
- Push lw x7,0(x1) / sw x8,4(x2) -> single issue twice. Push beq x1,x2,8 / addi x3,x0,1 -> beq issues alone.
- Fill buffer (DEPTH=4) with issue_stall=1 via two pair pushes -> fetch_ready=0 and outputs held. Release stall with an independent pair at head -> two pops, fetch_ready=1 next cycle.
- 3 entries buffered, assert flush with fetch_valid1=1 -> issue_valid1=0 that cycle; next cycle count=0, issue_valid1=0.
- Assert reset low mid-stream with 2 entries buffered -> next cycle issue_valid1=0, fetch_ready=1, all perf counters 0.
